// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter: buffered entry layout,
// source identifiers and register-file geometry.
package wb_arbiter_pkg;

    localparam int REG_W       = 5;
    localparam int DATA_W      = 32;
    localparam int NUM_REGS    = 1 << REG_W;
    // Stamps are carried at a fixed maximum width; the arbiter uses the low STAMP_W bits.
    localparam int STAMP_MAX_W = 16;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    typedef struct packed {
        logic [REG_W-1:0]       addr;
        logic [DATA_W-1:0]      data;
        logic [STAMP_MAX_W-1:0] stamp;
    } wb_entry_t;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback request/response bundle: two valid/ready request sources and the
// register-file write port plus pending-register mask.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                a_valid;
    logic                a_ready;
    logic [REG_W-1:0]    a_addr;
    logic [DATA_W-1:0]   a_data;

    logic                b_valid;
    logic                b_ready;
    logic [REG_W-1:0]    b_addr;
    logic [DATA_W-1:0]   b_data;

    logic                we3;
    logic [REG_W-1:0]    wa3;
    logic [DATA_W-1:0]   wd3;
    logic [NUM_REGS-1:0] pending_mask;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  we3, wa3, wd3, pending_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output we3, wa3, wd3, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO: circular storage with read/write pointers and an
// occupancy count, plus a mask of the registers its live entries target.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  wb_entry_t           i_entry,
    input  logic                i_pop,
    output logic                o_ready,
    output logic                o_nonempty,
    output wb_entry_t           o_head,
    output logic [NUM_REGS-1:0] o_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // A slot is live when its distance from the read pointer is below the count.
    function automatic logic slot_live(input int idx,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = PTR_W'(idx) - rd;
        return CNT_W'(off) < cnt;
    endfunction

    assign o_ready    = (r_count < CNT_W'(DEPTH));
    assign o_nonempty = (r_count != '0);
    assign o_head     = r_mem[r_rd_ptr];

    assign w_push = i_push && o_ready;
    assign w_pop  = i_pop && o_nonempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Register 0 is never written, so its entries never mark anything pending.
    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live(i, r_rd_ptr, r_count) && (r_mem[i].addr != '0)) begin
                o_pending[r_mem[i].addr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-source register-file writeback arbiter: buffers ALU and load-unit results,
// issues at most one per cycle and drives a registered write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int STAMP_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int unsigned STAMP_MASK_I = (1 << STAMP_W) - 1;
    localparam int unsigned STAMP_HALF_I = 1 << (STAMP_W - 1);
    localparam logic [STAMP_MAX_W-1:0] STAMP_MASK = STAMP_MAX_W'(STAMP_MASK_I);
    localparam logic [STAMP_MAX_W-1:0] STAMP_HALF = STAMP_MAX_W'(STAMP_HALF_I);

    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_a_push;
    logic                w_b_push;
    logic                w_a_pop;
    logic                w_b_pop;
    logic                w_a_nonempty;
    logic                w_b_nonempty;
    wb_entry_t           w_a_entry;
    wb_entry_t           w_b_entry;
    wb_entry_t           w_a_head;
    wb_entry_t           w_b_head;
    logic [NUM_REGS-1:0] w_a_pending;
    logic [NUM_REGS-1:0] w_b_pending;

    logic                w_issue;
    logic                w_dual;
    src_t                w_grant;
    logic [REG_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_write;

    logic [STAMP_W-1:0]  r_stamp;
    src_t                r_rr_ptr;
    logic                r_we3;
    logic [REG_W-1:0]    r_wa3;
    logic [DATA_W-1:0]   r_wd3;

    // A wins when its stamp is not younger than B's, comparing modulo 2^STAMP_W;
    // equal stamps (same-cycle pushes) resolve to A.
    function automatic logic a_first(input logic [STAMP_MAX_W-1:0] sa,
                                     input logic [STAMP_MAX_W-1:0] sb);
        logic [STAMP_MAX_W-1:0] diff;
        diff = (sa - sb) & STAMP_MASK;
        return (diff == '0) || (diff >= STAMP_HALF);
    endfunction

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign w_a_push    = bus.a_valid && w_a_ready;
    assign w_b_push    = bus.b_valid && w_b_ready;

    always_comb begin
        w_a_entry       = '0;
        w_a_entry.addr  = bus.a_addr;
        w_a_entry.data  = bus.a_data;
        w_a_entry.stamp = STAMP_MAX_W'(r_stamp);
        w_b_entry       = '0;
        w_b_entry.addr  = bus.b_addr;
        w_b_entry.data  = bus.b_data;
        w_b_entry.stamp = STAMP_MAX_W'(r_stamp);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_a_push),
        .i_entry    (w_a_entry),
        .i_pop      (w_a_pop),
        .o_ready    (w_a_ready),
        .o_nonempty (w_a_nonempty),
        .o_head     (w_a_head),
        .o_pending  (w_a_pending)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_b_push),
        .i_entry    (w_b_entry),
        .i_pop      (w_b_pop),
        .o_ready    (w_b_ready),
        .o_nonempty (w_b_nonempty),
        .o_head     (w_b_head),
        .o_pending  (w_b_pending)
    );

    assign bus.pending_mask = w_a_pending | w_b_pending;

    // Same-register heads must retire in arrival order; otherwise alternate.
    always_comb begin
        w_issue = 1'b0;
        w_dual  = 1'b0;
        w_grant = SRC_A;
        if (w_a_nonempty && w_b_nonempty) begin
            w_issue = 1'b1;
            w_dual  = 1'b1;
            if (w_a_head.addr == w_b_head.addr) begin
                w_grant = a_first(w_a_head.stamp, w_b_head.stamp) ? SRC_A : SRC_B;
            end else begin
                w_grant = r_rr_ptr;
            end
        end else if (w_a_nonempty) begin
            w_issue = 1'b1;
            w_grant = SRC_A;
        end else if (w_b_nonempty) begin
            w_issue = 1'b1;
            w_grant = SRC_B;
        end
    end

    assign w_a_pop    = w_issue && (w_grant == SRC_A);
    assign w_b_pop    = w_issue && (w_grant == SRC_B);
    assign w_sel_addr = (w_grant == SRC_A) ? w_a_head.addr : w_b_head.addr;
    assign w_sel_data = (w_grant == SRC_A) ? w_a_head.data : w_b_head.data;
    assign w_write    = w_issue && (w_sel_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stamp  <= '0;
            r_rr_ptr <= SRC_A;
            r_we3    <= 1'b0;
            r_wa3    <= '0;
            r_wd3    <= '0;
        end else begin
            if (w_a_push || w_b_push) begin
                r_stamp <= r_stamp + STAMP_W'(1);
            end
            if (w_dual) begin
                r_rr_ptr <= other_src(w_grant);
            end
            r_we3 <= w_write;
            if (w_write) begin
                r_wa3 <= w_sel_addr;
                r_wd3 <= w_sel_data;
            end
        end
    end

    assign bus.we3 = r_we3;
    assign bus.wa3 = r_wa3;
    assign bus.wd3 = r_wd3;

endmodule
